// File: rtl/knn_pkg.sv
// Shared types and constants for the KNN list sequencer and its ordered list.
package knn_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StSettle,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned ListSizeDef = 8;
  localparam int unsigned CompWDef    = 32;

  // A single-slot list still needs a one-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IdxWDef = idx_width(ListSizeDef);

  // Cleared slots hold the largest distance so any real candidate sorts ahead of them.
  localparam logic [CompWDef-1:0] CompClr = '1;

endpackage

// File: rtl/knn_slot_mux.sv
// Selects one (distance, label) slot from the flattened ordered-list contents.
module knn_slot_mux #(
  parameter int unsigned COMP_W    = 32,
  parameter int unsigned BAG_W     = 32,
  parameter int unsigned LIST_SIZE = 8,
  parameter int unsigned IDX_W     = 3
) (
  input  logic [COMP_W*LIST_SIZE-1:0] comp_all_i,
  input  logic [BAG_W*LIST_SIZE-1:0]  bag_all_i,
  input  logic [IDX_W-1:0]            idx_i,
  output logic [COMP_W-1:0]           comp_o,
  output logic [BAG_W-1:0]            bag_o
);

  assign comp_o = comp_all_i[int'(idx_i)*COMP_W +: COMP_W];
  assign bag_o  = bag_all_i[int'(idx_i)*BAG_W +: BAG_W];

endmodule

// File: rtl/knn_list_sched.sv
// Sequences one KNN query: clear the ordered list, stream candidates in, drain the K best.
module knn_list_sched
  import knn_pkg::*;
#(
  parameter int unsigned COMP_W    = 32,
  parameter int unsigned BAG_W     = 32,
  parameter int unsigned LIST_SIZE = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned IDX_W     = idx_width(LIST_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CNT_W-1:0]            num_pts,
  output logic                        busy,
  output logic                        done,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [COMP_W-1:0]           in_comp,
  input  logic [BAG_W-1:0]            in_bag,
  output logic                        list_clr,
  output logic                        list_valid,
  output logic [COMP_W-1:0]           list_comp,
  output logic [BAG_W-1:0]            list_bag,
  input  logic [COMP_W*LIST_SIZE-1:0] list_comp_all,
  input  logic [BAG_W*LIST_SIZE-1:0]  list_bag_all,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [COMP_W-1:0]           out_comp,
  output logic [BAG_W-1:0]            out_bag,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_last
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] nk_q, nk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             idx_last;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign idx_last = (CNT_W'(idx_q) == nk_q - CNT_W'(1));

  assign list_comp = in_comp;
  assign list_bag  = in_bag;
  assign out_idx   = idx_q;

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    nk_d       = nk_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    busy       = (state_q != StIdle);
    done       = 1'b0;
    in_ready   = 1'b0;
    list_clr   = 1'b0;
    list_valid = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d   = num_pts;
          nk_d    = (num_pts < CNT_W'(LIST_SIZE)) ? num_pts : CNT_W'(LIST_SIZE);
          cnt_d   = '0;
          state_d = (num_pts == '0) ? StDone : StClear;
        end
      end
      StClear: begin
        list_clr = 1'b1;
        cnt_d    = '0;
        state_d  = StFeed;
      end
      StFeed: begin
        in_ready   = 1'b1;
        list_valid = in_valid;
        if (in_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) state_d = StSettle;
        end
      end
      StSettle: begin
        idx_d   = '0;
        state_d = StDrain;
      end
      StDrain: begin
        out_valid = 1'b1;
        out_last  = idx_last;
        if (out_ready) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A handshake in the abort cycle still completes above; only the transition is overridden.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      num_q   <= '0;
      nk_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      nk_q    <= nk_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  knn_slot_mux #(
    .COMP_W    (COMP_W),
    .BAG_W     (BAG_W),
    .LIST_SIZE (LIST_SIZE),
    .IDX_W     (IDX_W)
  ) u_slot_mux (
    .comp_all_i (list_comp_all),
    .bag_all_i  (list_bag_all),
    .idx_i      (idx_q),
    .comp_o     (out_comp),
    .bag_o      (out_bag)
  );

endmodule

// File: tb/tb_knn_list_sched.sv
// Bench for knn_list_sched: behavioural ordered list plus a sort-based model of expected results.
module tb_knn_list_sched;
  import knn_pkg::*;

  localparam int unsigned COMP_W    = 32;
  localparam int unsigned BAG_W     = 32;
  localparam int unsigned LIST_SIZE = 8;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned IDX_W     = 3;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        start = 1'b0;
  logic                        abort = 1'b0;
  logic [CNT_W-1:0]            num_pts = '0;
  logic                        busy, done;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [COMP_W-1:0]           in_comp = '0;
  logic [BAG_W-1:0]            in_bag = '0;
  logic                        list_clr, list_valid;
  logic [COMP_W-1:0]           list_comp;
  logic [BAG_W-1:0]            list_bag;
  logic [COMP_W*LIST_SIZE-1:0] list_comp_all;
  logic [BAG_W*LIST_SIZE-1:0]  list_bag_all;
  logic                        out_valid;
  logic                        out_ready = 1'b1;
  logic [COMP_W-1:0]           out_comp;
  logic [BAG_W-1:0]            out_bag;
  logic [IDX_W-1:0]            out_idx;
  logic                        out_last;

  always #5 clk = ~clk;

  knn_list_sched #(
    .COMP_W    (COMP_W),
    .BAG_W     (BAG_W),
    .LIST_SIZE (LIST_SIZE),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .num_pts       (num_pts),
    .busy          (busy),
    .done          (done),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_comp       (in_comp),
    .in_bag        (in_bag),
    .list_clr      (list_clr),
    .list_valid    (list_valid),
    .list_comp     (list_comp),
    .list_bag      (list_bag),
    .list_comp_all (list_comp_all),
    .list_bag_all  (list_bag_all),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_comp      (out_comp),
    .out_bag       (out_bag),
    .out_idx       (out_idx),
    .out_last      (out_last)
  );

  // Ordered list the sequencer drives: registered insert, ties keep arrival order.
  logic [COMP_W-1:0] lc [LIST_SIZE];
  logic [BAG_W-1:0]  lb [LIST_SIZE];
  int                ins_pos;

  always @(posedge clk) begin
    if (list_clr) begin
      for (int j = 0; j < LIST_SIZE; j++) begin
        lc[j] <= CompClr;
        lb[j] <= '0;
      end
    end else if (list_valid) begin
      ins_pos = LIST_SIZE;
      for (int j = LIST_SIZE - 1; j >= 0; j--) if (list_comp < lc[j]) ins_pos = j;
      for (int j = 0; j < LIST_SIZE; j++) begin
        if (j == ins_pos) begin
          lc[j] <= list_comp;
          lb[j] <= list_bag;
        end else if (j > ins_pos) begin
          lc[j] <= lc[j-1];
          lb[j] <= lb[j-1];
        end
      end
    end
  end

  for (genvar g = 0; g < LIST_SIZE; g++) begin : g_flat
    assign list_comp_all[g*COMP_W +: COMP_W] = lc[g];
    assign list_bag_all[g*BAG_W +: BAG_W]    = lb[g];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic [COMP_W-1:0] cand_c[$];
  logic [BAG_W-1:0]  cand_b[$];
  logic [COMP_W-1:0] exp_c[$];
  logic [BAG_W-1:0]  exp_b[$];

  task automatic fill_rand(input int n);
    cand_c.delete();
    cand_b.delete();
    for (int i = 0; i < n; i++) begin
      cand_c.push_back(COMP_W'($urandom_range(0, 1000)));
      cand_b.push_back(BAG_W'($urandom));
    end
  endtask

  // Expected drain: repeatedly take the smallest remaining distance (earliest on ties).
  task automatic build_expected(input int n);
    logic [COMP_W-1:0] pc[$];
    logic [BAG_W-1:0]  pb[$];
    int m;
    int best;
    pc = cand_c;
    pb = cand_b;
    exp_c.delete();
    exp_b.delete();
    m = (n < LIST_SIZE) ? n : LIST_SIZE;
    for (int r = 0; r < m; r++) begin
      best = 0;
      for (int j = 1; j < pc.size(); j++) if (pc[j] < pc[best]) best = j;
      exp_c.push_back(pc[best]);
      exp_b.push_back(pb[best]);
      pc.delete(best);
      pb.delete(best);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check_eq({tag, "_list_clr"}, 64'(list_clr), 64'd0);
    check_eq({tag, "_list_valid"}, 64'(list_valid), 64'd0);
    check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_out_last"}, 64'(out_last), 64'd0);
    check_eq({tag, "_out_idx"}, 64'(out_idx), 64'd0);
  endtask

  // vmode: 0 always valid, 1 pattern 1,0,0, 2 random. rmode: 0 ready, 1 stall 5 per result,
  // 2 random. rst_at >= 0 pulses reset at that drain cycle and abandons the query.
  task automatic run_query(input int n, input int vmode, input int rmode, input int rst_at);
    int i, k, cyc, nk, stall;
    build_expected(n);
    nk = exp_c.size();
    @(negedge clk);
    start   = 1'b1;
    num_pts = CNT_W'(n);
    #1 check_eq("idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    if (n == 0) begin
      check_eq("zero_done", 64'(done), 64'd1);
      check_eq("zero_busy", 64'(busy), 64'd1);
      check_eq("zero_clr", 64'(list_clr), 64'd0);
      check_eq("zero_out_valid", 64'(out_valid), 64'd0);
      check_eq("zero_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      #1 check_eq("zero_idle_busy", 64'(busy), 64'd0);
      check_eq("zero_done_off", 64'(done), 64'd0);
      return;
    end
    check_eq("clear_clr", 64'(list_clr), 64'd1);
    check_eq("clear_in_ready", 64'(in_ready), 64'd0);
    i   = 0;
    cyc = 0;
    while (i < n) begin
      if (cyc >= 400) begin
        check_eq("feed_timeout", 64'd0, 64'd1);
        return;
      end
      @(negedge clk);
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 3 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_comp = cand_c[i];
      in_bag  = cand_b[i];
      #1 check_eq("feed_in_ready", 64'(in_ready), 64'd1);
      check_eq("feed_list_valid", 64'(list_valid), 64'(in_valid));
      if (in_valid) begin
        check_eq("feed_list_comp", 64'(list_comp), 64'(cand_c[i]));
        check_eq("feed_list_bag", 64'(list_bag), 64'(cand_b[i]));
        i++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_comp  = '0;
    in_bag   = '1;
    #1 check_eq("settle_in_ready", 64'(in_ready), 64'd0);
    check_eq("settle_list_valid", 64'(list_valid), 64'd0);
    check_eq("settle_out_valid", 64'(out_valid), 64'd0);
    check_eq("settle_busy", 64'(busy), 64'd1);
    k     = 0;
    cyc   = 0;
    stall = 0;
    while (k < nk) begin
      if (cyc >= 400) begin
        check_eq("drain_timeout", 64'd0, 64'd1);
        return;
      end
      if (rst_at >= 0 && cyc == rst_at) begin
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        #1 check_eq("rst_hold_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1 check_eq("rst_release_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1 check_eq("rst_after_busy", 64'(busy), 64'd0);
        check_eq("rst_after_done", 64'(done), 64'd0);
        return;
      end
      @(negedge clk);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (stall >= 5);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1 check_eq("drain_out_valid", 64'(out_valid), 64'd1);
      check_eq("drain_out_idx", 64'(out_idx), 64'(k));
      check_eq("drain_out_comp", 64'(out_comp), 64'(exp_c[k]));
      check_eq("drain_out_bag", 64'(out_bag), 64'(exp_b[k]));
      check_eq("drain_out_last", 64'(out_last), 64'(k == nk - 1));
      check_eq("drain_list_valid", 64'(list_valid), 64'd0);
      if (out_ready) begin
        k++;
        stall = 0;
      end else begin
        stall++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1 check_eq("done_pulse", 64'(done), 64'd1);
    check_eq("done_out_valid", 64'(out_valid), 64'd0);
    check_eq("done_busy", 64'(busy), 64'd1);
    @(negedge clk);
    #1 check_eq("post_done_busy", 64'(busy), 64'd0);
    check_eq("post_done_done", 64'(done), 64'd0);
  endtask

  task automatic run_abort();
    fill_rand(10);
    @(negedge clk);
    start   = 1'b1;
    num_pts = CNT_W'(10);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_comp  = cand_c[i];
      in_bag   = cand_b[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b1;
    #1 check_eq("abort_in_feed", 64'(in_ready), 64'd1);
    @(negedge clk);
    abort = 1'b0;
    #1 check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check_eq("abort_no_done", 64'(done), 64'd0);
    end
  endtask

  initial begin
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    cand_c = '{50, 3, 41, 7, 9, 100, 2, 88, 5, 60, 1, 30};
    cand_b.delete();
    for (int i = 0; i < 12; i++) cand_b.push_back(BAG_W'(i));
    run_query(12, 0, 0, -1);

    fill_rand(3);
    run_query(3, 0, 0, -1);

    cand_c.delete();
    cand_b.delete();
    run_query(0, 0, 0, -1);

    fill_rand(10);
    run_query(10, 1, 1, -1);

    run_abort();
    fill_rand(2);
    run_query(2, 0, 0, -1);

    fill_rand(5);
    run_query(5, 0, 1, 2);

    for (int q = 0; q < 6; q++) begin
      int n;
      n = $urandom_range(1, 20);
      fill_rand(n);
      run_query(n, 2, 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
